// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 codes, byte-lane masks and FSM states for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } lsu_state_t;

    // Width is funct3[1:0]: 00 byte, 01 half, 1x word.
    function automatic logic check_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        r = 1'b0;
        if (f3[1:0] == F3_H[1:0])
            r = off[0];
        else if (f3[1:0] == F3_W[1:0] || f3[1:0] == 2'b11)
            r = (off != 2'b00);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module   : lsu_load_align
// Brief    : Selects the byte/half of a memory word and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            2'd3:    w_byte = i_data[31:24];
            default: w_byte = i_data[7:0];
        endcase
        w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
    end

    always_comb begin
        o_rdata = i_data;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            default: o_rdata = i_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
// ============================================================================
// Module   : lsu_mem_initiator
// Brief    : Turns one core load/store into a single masked word-memory access.
// Options  : LSU_MISALIGN_TRAP_EN - trap misaligned H/W accesses instead of
//            issuing them aligned down (adds the lsu_misaligned port).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_start,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [31:0]       lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic [31:0]       lsu_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic              lsu_misaligned,
`endif
    output logic              request,
    output logic              we_re,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data_in,
    output logic [3:0]        mask,
    input  logic              valid,
    input  logic [31:0]       data_out
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;
    logic [1:0]  r_offset;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic        w_issue;
    logic        w_trap;
    logic        w_capture;
    logic        w_misalign;
    logic [3:0]  w_mask;
    logic [31:0] w_wdata;
    logic [31:0] w_load_val;
    logic        w_unused_addr;

    // Upper address bits wrap modulo the memory size.
    assign w_unused_addr = ^lsu_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = check_misaligned(lsu_funct3, lsu_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign lsu_busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_trap      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (lsu_start) begin
                    if (w_misalign) begin
                        w_trap      = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_issue     = 1'b1;
                        w_state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: w_state_nxt = r_we ? DONE : WAIT;
            WAIT: begin
                if (valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Halfword lanes follow offset[1] only, so a misaligned half lands aligned down.
    always_comb begin
        w_mask  = MASK_W;
        w_wdata = lsu_wdata;
        case (lsu_funct3[1:0])
            F3_B[1:0]: begin
                w_mask  = MASK_B << lsu_addr[1:0];
                w_wdata = {4{lsu_wdata[7:0]}};
            end
            F3_H[1:0]: begin
                w_mask  = MASK_H << {lsu_addr[1], 1'b0};
                w_wdata = {2{lsu_wdata[15:0]}};
            end
            default: begin
                w_mask  = MASK_W;
                w_wdata = lsu_wdata;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .i_data   (data_out),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_rdata  (w_load_val)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            request   <= 1'b0;
            we_re     <= 1'b0;
            address   <= '0;
            data_in   <= 32'd0;
            mask      <= 4'd0;
            lsu_done  <= 1'b0;
            lsu_rdata <= 32'd0;
            r_offset  <= 2'd0;
            r_funct3  <= 3'd0;
            r_we      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            lsu_misaligned <= 1'b0;
`endif
        end else begin
            request  <= w_issue;
            lsu_done <= (w_state_nxt == DONE);
`ifdef LSU_MISALIGN_TRAP_EN
            lsu_misaligned <= w_trap;
`endif
            if (w_issue) begin
                r_offset <= lsu_addr[1:0];
                r_funct3 <= lsu_funct3;
                r_we     <= lsu_we;
                we_re    <= lsu_we;
                address  <= lsu_addr[ADDR_W+1:2];
                mask     <= lsu_we ? w_mask : 4'd0;
                data_in  <= w_wdata;
            end
            if (w_capture)
                lsu_rdata <= w_load_val;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Brief    : Directed self-checking bench for lsu_mem_initiator with a word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_mem_initiator;
    import lsu_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              lsu_start;
    logic              lsu_we;
    logic [2:0]        lsu_funct3;
    logic [31:0]       lsu_addr;
    logic [31:0]       lsu_wdata;
    logic              lsu_busy;
    logic              lsu_done;
    logic [31:0]       lsu_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              lsu_misaligned;
`endif
    logic              request;
    logic              we_re;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [3:0]        mask;
    logic              valid = 1'b0;
    logic [31:0]       data_out = 32'd0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_start  (lsu_start),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_busy   (lsu_busy),
        .lsu_done   (lsu_done),
        .lsu_rdata  (lsu_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .lsu_misaligned (lsu_misaligned),
`endif
        .request    (request),
        .we_re      (we_re),
        .address    (address),
        .data_in    (data_in),
        .mask       (mask),
        .valid      (valid),
        .data_out   (data_out)
    );

    // Word memory: valid follows a read request by one edge unless hold_valid stalls it.
    logic [31:0]       mem [0:255];
    logic              hold_valid = 1'b0;
    logic              rd_pend = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[4]  <= 32'h80FF_7F01;
            valid   <= 1'b0;
            rd_pend <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (request && we_re) begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) mem[address][8*b +: 8] <= data_in[8*b +: 8];
            end else if (request && !we_re) begin
                if (hold_valid) begin
                    rd_pend <= 1'b1;
                    rd_addr <= address;
                end else begin
                    valid    <= 1'b1;
                    data_out <= mem[address];
                end
            end else if (rd_pend && !hold_valid) begin
                valid    <= 1'b1;
                data_out <= mem[rd_addr];
                rd_pend  <= 1'b0;
            end
        end
    end

    int cyc = 0;
    int n_req = 0;
    int n_done = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (request)  n_req  <= n_req + 1;
        if (lsu_done) n_done <= n_done + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Snapshot of the issue edge, the following edge and completion of one access.
    logic              s_req, s_we, s_req1, s_done_after, s_busy_after, s_mis;
    logic [ADDR_W-1:0] s_addr;
    logic [3:0]        s_mask;
    logic [31:0]       s_data;
    int                s_lat;

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic keep);
        int n;
        @(negedge clk);
        lsu_start = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
        @(posedge clk); #1;
        n = cyc;
        s_req = request; s_we = we_re; s_addr = address; s_mask = mask; s_data = data_in;
        s_req1 = request; s_lat = -1; s_mis = 1'b0;
        if (lsu_done) begin
            s_lat = 0;
`ifdef LSU_MISALIGN_TRAP_EN
            s_mis = lsu_misaligned;
`endif
        end
        if (!keep) begin
            @(negedge clk);
            lsu_start = 1'b0;
        end
        for (int i = 0; i < 20 && s_lat < 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) s_req1 = request;
            if (lsu_done) s_lat = cyc - n;
        end
        @(negedge clk);
        lsu_start = 1'b0;
        @(posedge clk); #1;
        s_done_after = lsu_done;
        s_busy_after = lsu_busy;
    endtask

    initial begin
        int r0, d0;
        logic got;
        lsu_start = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_request", request, 1'b0);
        check("rst_we_re", we_re, 1'b0);
        check("rst_done", lsu_done, 1'b0);
        check("rst_mask", mask, 4'd0);
        check("rst_address", address, 8'd0);
        check("rst_data_in", data_in, 32'd0);
        check("rst_rdata", lsu_rdata, 32'd0);
        check("rst_busy", lsu_busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        run(1'b1, F3_B, 32'h0000_0005, 32'h0000_00AB, 1'b0);
        check("sb_request", s_req, 1'b1);
        check("sb_we_re", s_we, 1'b1);
        check("sb_address", s_addr, 8'd1);
        check("sb_mask", s_mask, 4'b0010);
        check("sb_data_in", s_data, 32'hABAB_ABAB);
        check("sb_request_drop", s_req1, 1'b0);
        check("sb_latency", s_lat, 32'd1);
        check("sb_done_width", s_done_after, 1'b0);
        check("sb_busy_after", s_busy_after, 1'b0);
        check("sb_mem", mem[1], 32'h0000_AB00);

        run(1'b0, F3_B, 32'h13, 32'd0, 1'b0);
        check("lb13_rdata", lsu_rdata, 32'hFFFF_FF80);
        check("lb13_latency", s_lat, 32'd2);
        check("lb13_mask", s_mask, 4'd0);
        check("lb13_we_re", s_we, 1'b0);
        check("lb13_address", s_addr, 8'd4);
        run(1'b0, F3_BU, 32'h13, 32'd0, 1'b0);
        check("lbu13_rdata", lsu_rdata, 32'h0000_0080);
        run(1'b0, F3_B, 32'h12, 32'd0, 1'b0);
        check("lb12_rdata", lsu_rdata, 32'hFFFF_FFFF);
        run(1'b0, F3_B, 32'h11, 32'd0, 1'b0);
        check("lb11_rdata", lsu_rdata, 32'h0000_007F);

        run(1'b1, F3_H, 32'h12, 32'h0000_BEEF, 1'b0);
        check("sh_mask", s_mask, 4'b1100);
        check("sh_data_in", s_data, 32'hBEEF_BEEF);
        check("sh_latency", s_lat, 32'd1);
        check("sh_mem", mem[4], 32'hBEEF_7F01);
        run(1'b0, F3_H, 32'h12, 32'd0, 1'b0);
        check("lh12_rdata", lsu_rdata, 32'hFFFF_BEEF);
        run(1'b0, F3_HU, 32'h12, 32'd0, 1'b0);
        check("lhu12_rdata", lsu_rdata, 32'h0000_BEEF);
        check("lhu12_latency", s_lat, 32'd2);
        run(1'b0, F3_H, 32'h10, 32'd0, 1'b0);
        check("lh10_rdata", lsu_rdata, 32'h0000_7F01);

        run(1'b1, F3_W, 32'h20, 32'h1234_5678, 1'b0);
        check("sw_mask", s_mask, 4'b1111);
        check("sw_data_in", s_data, 32'h1234_5678);
        check("sw_address", s_addr, 8'd8);
        run(1'b0, F3_W, 32'h20, 32'd0, 1'b0);
        check("lw20_rdata", lsu_rdata, 32'h1234_5678);
        run(1'b0, F3_HU, 32'h20, 32'd0, 1'b0);
        check("lhu20_rdata", lsu_rdata, 32'h0000_5678);
        run(1'b0, F3_BU, 32'h21, 32'd0, 1'b0);
        check("lbu21_rdata", lsu_rdata, 32'h0000_0056);
        run(1'b0, F3_W, 32'h0000_0420, 32'd0, 1'b0);
        check("wrap_address", s_addr, 8'd8);
        check("wrap_rdata", lsu_rdata, 32'h1234_5678);

        r0 = n_req; d0 = n_done;
        run(1'b0, F3_B, 32'h20, 32'd0, 1'b1);
        check("busy_start_requests", n_req - r0, 32'd1);
        check("busy_start_dones", n_done - d0, 32'd1);
        check("busy_start_rdata", lsu_rdata, 32'h0000_0078);

        hold_valid = 1'b1;
        @(negedge clk);
        lsu_start = 1'b1; lsu_we = 1'b0; lsu_funct3 = F3_HU; lsu_addr = 32'h22;
        @(negedge clk);
        lsu_start = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_busy", lsu_busy, 1'b1);
        check("stall_no_done", lsu_done, 1'b0);
        hold_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (lsu_done) got = 1'b1;
        end
        check("stall_done", got, 1'b1);
        check("stall_rdata", lsu_rdata, 32'h0000_1234);
        @(negedge clk);
        @(posedge clk); #1;

        r0 = n_req;
        run(1'b0, F3_W, 32'h06, 32'd0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lw_request", s_req, 1'b0);
        check("mis_lw_latency", s_lat, 32'd0);
        check("mis_lw_flag", s_mis, 1'b1);
        check("mis_lw_rdata", lsu_rdata, 32'h0000_1234);
        check("mis_lw_no_req", n_req - r0, 32'd0);
`else
        check("mis_lw_request", s_req, 1'b1);
        check("mis_lw_address", s_addr, 8'd1);
        check("mis_lw_latency", s_lat, 32'd2);
        check("mis_lw_rdata", lsu_rdata, 32'h0000_AB00);
`endif
        run(1'b1, F3_H, 32'h23, 32'h0000_1111, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_sh_request", s_req, 1'b0);
        check("mis_sh_flag", s_mis, 1'b1);
        check("mis_sh_mem", mem[8], 32'h1234_5678);
`else
        check("mis_sh_mask", s_mask, 4'b1100);
        check("mis_sh_data_in", s_data, 32'h1111_1111);
        check("mis_sh_mem", mem[8], 32'h1111_5678);
`endif

        hold_valid = 1'b1;
        @(negedge clk);
        lsu_start = 1'b1; lsu_we = 1'b0; lsu_funct3 = F3_W; lsu_addr = 32'h20;
        @(negedge clk);
        lsu_start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_request", request, 1'b0);
        check("arst_done", lsu_done, 1'b0);
        check("arst_mask", mask, 4'd0);
        check("arst_busy", lsu_busy, 1'b0);
        check("arst_rdata", lsu_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        hold_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_busy", lsu_busy, 1'b0);
        check("post_rst_request", request, 1'b0);
        run(1'b0, F3_BU, 32'h13, 32'd0, 1'b0);
        check("post_rst_lbu_rdata", lsu_rdata, 32'h0000_0080);
        check("post_rst_lbu_latency", s_lat, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
